// File: rtl/bus_request_sequencer_pkg.sv
// Shared encodings for the bus request sequencer: bus FSM states, request sizes,
// bus-cycle sizes and the sequencer's own state enum.
package bus_request_sequencer_pkg;

    localparam logic [3:0] STATE_IDLE       = 4'd0;
    localparam logic [3:0] STATE_WAKEUP     = 4'd1;
    localparam logic [3:0] STATE_DRIVE      = 4'd2;
    localparam logic [3:0] STATE_WAIT_DSACK = 4'd3;
    localparam logic [3:0] STATE_LATCH      = 4'd4;
    localparam logic [3:0] STATE_FINALIZE   = 4'd5;
    localparam logic [3:0] STATE_CONTINUE   = 4'd6;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_WORD = 2'b01,
        SIZE_LONG = 2'b10,
        SIZE_RSVD = 2'b11
    } req_size_e;

    localparam logic [1:0] BUS_SIZE_BYTE = 2'b01;
    localparam logic [1:0] BUS_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_RUN  = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_e;

    // Even byte addresses live on the high lane of the 16-bit bus.
    function automatic logic [7:0] pick_byte(input logic [15:0] data, input logic odd);
        return odd ? data[7:0] : data[15:8];
    endfunction

endpackage

// File: rtl/bus_request_sequencer_if.sv
// Request, FSM-control and bus-cycle signals of the bus request sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface bus_request_sequencer_if #(
    parameter int ADDR_W = 24
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [1:0]        REQ_SIZE;
    logic              REQ_RW;
    logic [31:0]       REQ_WDATA;
    logic [3:0]        FSM_STATE;
    logic              ACTIVATE;
    logic              MUST_CONTINUE;
    logic [ADDR_W-1:0] BUS_ADDR;
    logic [1:0]        BUS_SIZE;
    logic              BUS_RW;
    logic [15:0]       BUS_WDATA;
    logic [15:0]       BUS_RDATA;
    logic              RSP_VALID;
    logic [31:0]       RSP_RDATA;
    logic              RSP_ERROR;

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_SIZE, REQ_RW, REQ_WDATA, FSM_STATE, BUS_RDATA,
        output REQ_READY, ACTIVATE, MUST_CONTINUE, BUS_ADDR, BUS_SIZE, BUS_RW, BUS_WDATA,
               RSP_VALID, RSP_RDATA, RSP_ERROR
    );

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_SIZE, REQ_RW, REQ_WDATA, FSM_STATE, BUS_RDATA,
        input  REQ_READY, ACTIVATE, MUST_CONTINUE, BUS_ADDR, BUS_SIZE, BUS_RW, BUS_WDATA,
               RSP_VALID, RSP_RDATA, RSP_ERROR
    );
endinterface

// File: rtl/bus_request_sequencer_req_queue2.sv
// Two-slot request queue: slot 0 is the ACTIVE request, slot 1 the PENDING one.
// Retiring promotes PENDING into ACTIVE on the same edge.
module bus_request_sequencer_req_queue2 #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         nRESET,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    input  logic         retire,
    output logic         act_valid,
    output logic [W-1:0] act_data
);
    logic         valid_q [2];
    logic         valid_d [2];
    logic [W-1:0] data_q  [2];
    logic [W-1:0] data_d  [2];
    logic         accept;

    assign push_ready = !valid_q[1];
    assign accept     = push_valid && push_ready;
    assign act_valid  = valid_q[0];
    assign act_data   = data_q[0];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (retire) begin
            valid_d[0] = valid_q[1];
            data_d[0]  = data_q[1];
            valid_d[1] = 1'b0;
        end
        // Accept implies PENDING is empty, so a retiring cycle always frees ACTIVE.
        if (accept) begin
            if (retire || !valid_q[0]) begin
                valid_d[0] = 1'b1;
                data_d[0]  = push_data;
            end else begin
                valid_d[1] = 1'b1;
                data_d[1]  = push_data;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge CLK or negedge nRESET) begin
            if (!nRESET) begin
                valid_q[gi] <= 1'b0;
                data_q[gi]  <= '0;
            end else begin
                valid_q[gi] <= valid_d[gi];
                data_q[gi]  <= data_d[gi];
            end
        end
    end

endmodule

// File: rtl/bus_request_sequencer.sv
// Sequencer feeding the bus FSM: queues requests, splits longwords, assembles read data.
// Build option: define ALIGN_CHECK_EN to reject odd-address word/long requests with no bus cycle.
module bus_request_sequencer
    import bus_request_sequencer_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic                   CLK,
    input  logic                   nRESET,
    bus_request_sequencer_if.slave bus
);
    localparam int ENTRY_W = ADDR_W + 2 + 1 + 32;

    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] act_data;
    logic               push_ready;
    logic               act_valid;
    logic               retire;
    logic               reject;
    logic [ADDR_W-1:0]  act_addr;
    req_size_e          act_size;
    logic               act_rw;
    logic [31:0]        act_wdata;

    seq_state_e        seq_state_q, seq_state_d;
    logic              activate_q, activate_d;
    logic              must_continue_q, must_continue_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic              bus_rw_q, bus_rw_d;
    logic [15:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    assign push_data = {bus.REQ_ADDR, bus.REQ_SIZE, bus.REQ_RW, bus.REQ_WDATA};
    assign act_addr  = act_data[ENTRY_W-1 -: ADDR_W];
    assign act_size  = req_size_e'(act_data[34:33]);
    assign act_rw    = act_data[32];
    assign act_wdata = act_data[31:0];

    bus_request_sequencer_req_queue2 #(.W(ENTRY_W)) u_queue (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .push_valid (bus.REQ_VALID),
        .push_data  (push_data),
        .push_ready (push_ready),
        .retire     (retire),
        .act_valid  (act_valid),
        .act_data   (act_data)
    );

`ifdef ALIGN_CHECK_EN
    assign reject = (act_size == SIZE_RSVD) ||
                    (((act_size == SIZE_WORD) || (act_size == SIZE_LONG)) && act_addr[0]);
`else
    assign reject = (act_size == SIZE_RSVD);
`endif

    always_comb begin
        seq_state_d     = seq_state_q;
        activate_d      = activate_q;
        must_continue_d = must_continue_q;
        bus_addr_d      = bus_addr_q;
        bus_size_d      = bus_size_q;
        bus_rw_d        = bus_rw_q;
        bus_wdata_d     = bus_wdata_q;
        rdata_d         = rdata_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_valid_d     = 1'b0;
        rsp_error_d     = 1'b0;
        retire          = 1'b0;

        case (seq_state_q)
            SEQ_IDLE: begin
                if (act_valid) seq_state_d = SEQ_LOAD;
            end
            SEQ_LOAD: begin
                rdata_d = '0;
                if (reject) begin
                    seq_state_d = SEQ_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    retire      = 1'b1;
                end else begin
                    seq_state_d = SEQ_RUN;
                    activate_d  = 1'b1;
                    bus_addr_d  = act_addr;
                    bus_rw_d    = act_rw;
                    case (act_size)
                        SIZE_LONG: begin
                            bus_size_d      = BUS_SIZE_WORD;
                            bus_wdata_d     = act_wdata[31:16];
                            must_continue_d = 1'b1;
                        end
                        SIZE_WORD: begin
                            bus_size_d      = BUS_SIZE_WORD;
                            bus_wdata_d     = act_wdata[15:0];
                            must_continue_d = 1'b0;
                        end
                        default: begin
                            bus_size_d      = BUS_SIZE_BYTE;
                            bus_wdata_d     = {act_wdata[7:0], act_wdata[7:0]};
                            must_continue_d = 1'b0;
                        end
                    endcase
                end
            end
            SEQ_RUN: begin
                if (bus.FSM_STATE == STATE_WAKEUP) activate_d = 1'b0;
                // MUST_CONTINUE still high marks the first half of a longword.
                if (bus.FSM_STATE == STATE_LATCH) begin
                    if ((act_size == SIZE_LONG) && must_continue_q)
                        rdata_d[31:16] = bus.BUS_RDATA;
                    else if (act_size == SIZE_BYTE)
                        rdata_d = {24'h0, pick_byte(bus.BUS_RDATA, bus_addr_q[0])};
                    else
                        rdata_d[15:0] = bus.BUS_RDATA;
                end
                if ((bus.FSM_STATE == STATE_CONTINUE) && must_continue_q) begin
                    bus_addr_d      = bus_addr_q + ADDR_W'(2);
                    bus_wdata_d     = act_wdata[15:0];
                    must_continue_d = 1'b0;
                end
                if ((bus.FSM_STATE == STATE_FINALIZE) && !must_continue_q) begin
                    seq_state_d = SEQ_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_rw_q ? rdata_q : 32'h0;
                    retire      = 1'b1;
                end
            end
            SEQ_DONE: begin
                seq_state_d = SEQ_IDLE;
            end
            default: begin
                seq_state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            seq_state_q     <= SEQ_IDLE;
            activate_q      <= 1'b0;
            must_continue_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_size_q      <= '0;
            bus_rw_q        <= 1'b0;
            bus_wdata_q     <= '0;
            rdata_q         <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_error_q     <= 1'b0;
        end else begin
            seq_state_q     <= seq_state_d;
            activate_q      <= activate_d;
            must_continue_q <= must_continue_d;
            bus_addr_q      <= bus_addr_d;
            bus_size_q      <= bus_size_d;
            bus_rw_q        <= bus_rw_d;
            bus_wdata_q     <= bus_wdata_d;
            rdata_q         <= rdata_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_error_q     <= rsp_error_d;
        end
    end

    assign bus.REQ_READY     = push_ready;
    assign bus.ACTIVATE      = activate_q;
    assign bus.MUST_CONTINUE = must_continue_q;
    assign bus.BUS_ADDR      = bus_addr_q;
    assign bus.BUS_SIZE      = bus_size_q;
    assign bus.BUS_RW        = bus_rw_q;
    assign bus.BUS_WDATA     = bus_wdata_q;
    assign bus.RSP_VALID     = rsp_valid_q;
    assign bus.RSP_RDATA     = rsp_rdata_q;
    assign bus.RSP_ERROR     = rsp_error_q;

endmodule
